data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 16-bit data words held.
REQ-002 SHALL have parameter WAIT, default 2, number of access cycles spent in BUSY (legal range 0-15).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port req, input, 1 bit, load/store request from the CPU.
REQ-006 SHALL have port we, input, 1 bit; 1 means store (SW), 0 means load (LW).
REQ-007 SHALL have port addr, input, 8 bits, byte address; word index is addr[7:1].
REQ-008 SHALL have port wdata, input, 16 bits, store data.
REQ-009 SHALL have port ready, output, 1 bit, responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid, output, 1 bit, response present.
REQ-011 SHALL have port resp_ack, input, 1 bit, CPU consumes the response.
REQ-012 SHALL have port rdata, output, 16 bits, load data.
REQ-013 SHALL have port err, output, 1 bit, access fault flag, valid while resp_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 SHALL drive ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 SHALL accept a request at a rising edge where req=1 and ready=1, capturing we, addr and wdata into internal registers; later input changes have no effect on that access.
REQ-017 SHALL, on acceptance, go IDLE->BUSY with the wait counter loaded to WAIT-1 when WAIT>0, or IDLE->RESP directly when WAIT=0.
REQ-018 SHALL decrement the counter each cycle in BUSY and go BUSY->RESP on the edge where the counter is 0.
REQ-019 SHALL give an accept-to-resp_valid latency of exactly WAIT+1 rising edges.
REQ-020 SHALL flag a fault when captured addr[0]=1 (misaligned) or addr[7:1] >= DEPTH (out of range).
REQ-021 SHALL commit a fault-free store to the memory word on the edge entering RESP, with rdata=0 and err=0 in RESP.
REQ-022 SHALL, for a fault-free load, present the word read at entry to RESP on rdata with err=0, held stable throughout RESP.
REQ-023 SHALL, for a faulting access, perform no memory write and present rdata=0, err=1.
REQ-024 SHALL hold RESP, with outputs stable, until a rising edge with resp_ack=1, then go RESP->IDLE; ready rises in the cycle after the ack edge, so back-to-back accesses are separated by at least one IDLE cycle.
REQ-025 SHALL ignore req outside IDLE and resp_ack outside RESP.
REQ-026 SHALL make a load issued right after a store to the same word return the new data.

Reset
REQ-027 SHALL, while reset_n=0, immediately force state IDLE, counter 0, ready=1, resp_valid=0, rdata=0 and err=0.
REQ-028 SHALL leave memory contents unchanged by reset; contents are zero at time 0 only.
REQ-029 SHALL abort an in-flight access when reset asserts in BUSY: no store commit, no response after reset releases.
REQ-030 SHALL accept a request on the first rising edge after reset_n returns to 1.

Verification
REQ-031 Store then load, WAIT=2: SW addr=8'h10 wdata=16'hBEEF -> resp_valid on 3rd edge after accept, err=0; after ack, LW addr=8'h10 -> rdata=16'hBEEF, err=0.
REQ-032 Misaligned access: SW addr=8'h11 wdata=16'h1234 -> err=1, rdata=0; LW addr=8'h10 still returns 16'hBEEF.
REQ-033 Out of range, DEPTH=64: LW addr=8'h80 -> err=1, rdata=16'h0000.
REQ-034 Response hold and ignored req: keep resp_ack=0 for 5 cycles -> rdata/err stable, ready=0, a req=1 pulse during RESP is not accepted; ack -> ready=1 next cycle.
REQ-035 Reset mid-access: SW addr=8'h20 wdata=16'h5555, reset_n=0 during BUSY -> resp_valid=0, ready=1; later LW addr=8'h20 -> rdata=16'h0000.
REQ-036 WAIT=0 build: LW addr=8'h00 -> resp_valid on the edge after accept, rdata=16'h0000.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder : word memory answering LW/SW requests after WAIT cyc  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        resp_valid,
   input  logic        resp_ack,
   output logic [15:0] rdata,
   output logic        err
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          WAIT_M1   = (WAIT > 0) ? WAIT - 1 : 0;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_M1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [7:0]  addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [15:0] mem_q [DEPTH] = '{default: '0};

   logic        w_we;
   logic [7:0]  w_addr;
   logic [15:0] w_wdata;
   logic [6:0]  w_idx;
   logic        w_fault;
   logic        w_mem_we;

   // With WAIT=0 the access completes on its own accept edge, so the live
   // inputs stand in for the not-yet-captured registers while in IDLE.
   assign w_we    = (state_q == S_IDLE) ? we    : we_q;
   assign w_addr  = (state_q == S_IDLE) ? addr  : addr_q;
   assign w_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
   assign w_idx   = w_addr[7:1];
   assign w_fault = w_addr[0] || (32'(w_idx) >= DEPTH);

   always_comb begin
      logic enter_resp;
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      w_mem_we   = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (WAIT == 0) begin
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         state_d  = S_RESP;
         cnt_d    = 4'd0;
         err_d    = w_fault;
         rdata_d  = (!w_fault && !w_we) ? mem_q[w_idx[AW-1:0]] : 16'h0000;
         // reset_n gates the commit so an edge seen while in reset never writes
         w_mem_we = !w_fault && w_we && reset_n;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == S_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

   // Memory has no reset: contents survive reset_n.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         mem_q[w_idx[AW-1:0]] <= w_wdata;
      end
   end

   assign ready      = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign rdata      = rdata_q;
   assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder : scoreboard bench, WAIT=2 and WAIT=0 instances     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        go = 1'b0;
   logic        ack = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [15:0] wdata = 16'h0000;
   int          sel = 0;

   logic        req2, ack2, ready2, rv2, err2;
   logic        req0, ack0, ready0, rv0, err0;
   logic [15:0] rdata2, rdata0;
   logic        ob_ready, ob_rv, ob_err;
   logic [15:0] ob_rdata;

   exp_t        sbq[$];
   logic [15:0] mdl [2][128];
   int          n_chk = 0;
   int          n_bad = 0;

   assign req2 = go  && (sel == 0);
   assign ack2 = ack && (sel == 0);
   assign req0 = go  && (sel == 1);
   assign ack0 = ack && (sel == 1);
   assign ob_ready = (sel == 0) ? ready2 : ready0;
   assign ob_rv    = (sel == 0) ? rv2    : rv0;
   assign ob_err   = (sel == 0) ? err2   : err0;
   assign ob_rdata = (sel == 0) ? rdata2 : rdata0;

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH(64), .WAIT(2)) u_dut (
      .clock(clock), .reset_n(reset_n), .req(req2), .we(we), .addr(addr),
      .wdata(wdata), .ready(ready2), .resp_valid(rv2), .resp_ack(ack2),
      .rdata(rdata2), .err(err2)
   );

   data_mem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .req(req0), .we(we), .addr(addr),
      .wdata(wdata), .ready(ready0), .resp_valid(rv0), .resp_ack(ack0),
      .rdata(rdata0), .err(err0)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One complete access on the selected instance; expected result comes from
   // the reference model and travels through the scoreboard queue.
   task automatic access(input int s, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input int hold, input bit poke);
      exp_t e;
      int   n;
      bit   fault;
      sel   = s;
      we    = w;
      addr  = a;
      wdata = d;
      fault = a[0] || (a[7:1] >= 7'd64);
      if (fault)  e = '{rdata: 16'h0000, err: 1'b1};
      else if (w) begin
         mdl[s][a[7:1]] = d;
         e = '{rdata: 16'h0000, err: 1'b0};
      end else    e = '{rdata: mdl[s][a[7:1]], err: 1'b0};
      sbq.push_back(e);
      chk_val("ready_before_req", 32'(ob_ready), 32'd1);
      go = 1'b1;
      @(posedge clock); #1;
      go    = 1'b0;
      we    = 1'($urandom);
      addr  = 8'($urandom);
      wdata = 16'($urandom);
      n = 0;
      while (!ob_rv && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk_val("latency", 32'(n), (s == 0) ? 32'd2 : 32'd0);
      e = sbq.pop_front();
      chk_val("rdata", 32'(ob_rdata), 32'(e.rdata));
      chk_val("err", 32'(ob_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         go = poke;
         @(posedge clock); #1;
         go = 1'b0;
         chk_val("hold_resp_valid", 32'(ob_rv), 32'd1);
         chk_val("hold_ready", 32'(ob_ready), 32'd0);
         chk_val("hold_rdata", 32'(ob_rdata), 32'(e.rdata));
         chk_val("hold_err", 32'(ob_err), 32'(e.err));
      end
      ack = 1'b1;
      @(posedge clock); #1;
      ack = 1'b0;
      chk_val("ready_after_ack", 32'(ob_ready), 32'd1);
      chk_val("rv_after_ack", 32'(ob_rv), 32'd0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 128; k++) mdl[s][k] = 16'h0000;

      #2 reset_n = 1'b0;
      #1;
      chk_val("rst_ready", 32'(ready2), 32'd1);
      chk_val("rst_resp_valid", 32'(rv2), 32'd0);
      chk_val("rst_rdata", 32'(rdata2), 32'd0);
      chk_val("rst_err", 32'(err2), 32'd0);
      chk_val("rst_ready_w0", 32'(ready0), 32'd1);
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;

      access(0, 1'b1, 8'h10, 16'hBEEF, 0, 1'b0);
      access(0, 1'b0, 8'h10, 16'h0000, 0, 1'b0);
      chk_val("sw_lw_beef", 32'(mdl[0][8]), 32'hBEEF);
      access(0, 1'b1, 8'h11, 16'h1234, 0, 1'b0);
      access(0, 1'b0, 8'h10, 16'h0000, 0, 1'b0);
      access(0, 1'b0, 8'h80, 16'h0000, 0, 1'b0);
      access(0, 1'b0, 8'h10, 16'h0000, 5, 1'b1);

      // reset asserted while the store sits in BUSY
      @(negedge clock);
      sel = 0; we = 1'b1; addr = 8'h20; wdata = 16'h5555; go = 1'b1;
      @(posedge clock); #1;
      go = 1'b0;
      chk_val("busy_no_resp", 32'(rv2), 32'd0);
      reset_n = 1'b0;
      #1;
      chk_val("abort_ready", 32'(ready2), 32'd1);
      chk_val("abort_resp_valid", 32'(rv2), 32'd0);
      chk_val("abort_rdata", 32'(rdata2), 32'd0);
      chk_val("abort_err", 32'(err2), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk_val("no_resp_after_abort", 32'(rv2), 32'd0);
      end
      access(0, 1'b0, 8'h20, 16'h0000, 0, 1'b0);
      access(0, 1'b0, 8'h10, 16'h0000, 0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         logic [7:0] ra;
         ra = 8'($urandom_range(0, 150));
         if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
         access(0, 1'($urandom), ra, 16'($urandom), int'($urandom_range(0, 2)), 1'b1);
      end

      access(1, 1'b0, 8'h00, 16'h0000, 0, 1'b0);
      access(1, 1'b1, 8'h04, 16'hABCD, 1, 1'b1);
      access(1, 1'b0, 8'h04, 16'h0000, 0, 1'b0);
      access(1, 1'b0, 8'h7F, 16'h0000, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
